// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: ceil-log2, read-mode constants and
// elaboration-time parameter validation.
package fifo_pkg;

   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   // DEPTH must be a power of two so the pointers can wrap without compare logic.
   function automatic bit fifo_params_ok(input int depth, input int af_level,
                                         input int ae_level, input int fwft);
      return (depth >= 2) && is_pow2(depth) &&
             (af_level >= 1) && (af_level <= depth) &&
             (ae_level >= 0) && (ae_level <= depth - 1) &&
             ((fwft == FIFO_MODE_REG) || (fwft == FIFO_MODE_FWFT));
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Single-clock 1W1R register array: synchronous write, asynchronous read.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int D_WIDTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_wr_en,
   input  logic [clog2(DEPTH)-1:0]   i_wr_addr,
   input  logic [D_WIDTH-1:0]        i_wr_data,
   input  logic [clog2(DEPTH)-1:0]   i_rd_addr,
   output logic [D_WIDTH-1:0]        o_rd_data
);

   logic [D_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// sticky error flags and write-through when full with a simultaneous read.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int D_WIDTH  = 8,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = FIFO_MODE_REG
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [D_WIDTH-1:0]       wr_data,
   input  logic                     rd_en,
   output logic [D_WIDTH-1:0]       rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [clog2(DEPTH):0]    count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);

   if (!fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_param_err
      $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL/FWFT combination");
   end

   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic               r_overflow;
   logic               r_underflow;
   logic               w_full;
   logic               w_empty;
   logic               w_rd_acc;
   logic               w_wr_acc;
   logic [D_WIDTH-1:0] w_head;

   assign w_full   = (r_count == DEPTH_C);
   assign w_empty  = (r_count == '0);
   assign w_rd_acc = rd_en & ~w_empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

   fifo_ram #(
      .DEPTH   (DEPTH),
      .D_WIDTH (D_WIDTH)
   ) u_ram (
      .i_clk     (clk),
      .i_wr_en   (w_wr_acc & reset_n),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (wr_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_head)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
         // A fresh error outranks a coincident clear.
         if (wr_en & ~w_wr_acc)  r_overflow  <= 1'b1;
         else if (clr_err)       r_overflow  <= 1'b0;
         if (rd_en & ~w_rd_acc)  r_underflow <= 1'b1;
         else if (clr_err)       r_underflow <= 1'b0;
      end
   end

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rd_data  = w_head;
      assign rd_valid = ~w_empty;
   end else begin : g_reg
      logic [D_WIDTH-1:0] r_rd_data;
      logic               r_rd_valid;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            if (w_rd_acc) r_rd_data <= w_head;
            r_rd_valid <= w_rd_acc;
         end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
   end

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= AF_C);
   assign almost_empty = (r_count <= AE_C);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read instance (DEPTH=8) driven from a
// vector table plus a FWFT instance (DEPTH=4); read data is scoreboarded.
module tb_sync_fifo_param;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // Registered-read instance, DEPTH=8
   logic       d_wr = 1'b0, d_rd = 1'b0, d_clr = 1'b0;
   logic [7:0] d_wdata = 8'h00;
   logic [7:0] d_rd_data;
   logic       d_rd_valid, d_full, d_empty, d_af, d_ae, d_ovf, d_udf;
   logic [3:0] d_count;

   sync_fifo_param #(.DEPTH(8), .D_WIDTH(8), .FWFT(0)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (d_wr),
      .wr_data      (d_wdata),
      .rd_en        (d_rd),
      .rd_data      (d_rd_data),
      .rd_valid     (d_rd_valid),
      .full         (d_full),
      .empty        (d_empty),
      .almost_full  (d_af),
      .almost_empty (d_ae),
      .count        (d_count),
      .overflow     (d_ovf),
      .underflow    (d_udf),
      .clr_err      (d_clr)
   );

   // FWFT instance, DEPTH=4
   logic       f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
   logic [7:0] f_wdata = 8'h00;
   logic [7:0] f_rd_data;
   logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [2:0] f_count;

   sync_fifo_param #(.DEPTH(4), .D_WIDTH(8), .FWFT(1)) u_fwft (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (f_wr),
      .wr_data      (f_wdata),
      .rd_en        (f_rd),
      .rd_data      (f_rd_data),
      .rd_valid     (f_rd_valid),
      .full         (f_full),
      .empty        (f_empty),
      .almost_full  (f_af),
      .almost_empty (f_ae),
      .count        (f_count),
      .overflow     (f_ovf),
      .underflow    (f_udf),
      .clr_err      (f_clr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] model_q[$];   // contents the DEPTH=8 FIFO should hold
   logic [7:0] exp_q[$];     // read data expected on the next rd_valid
   logic [7:0] f_q[$];       // contents the FWFT FIFO should hold

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic       rd;
      logic       clr;
      logic [3:0] cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input logic wr, input logic [7:0] data, input logic rd,
                                   input logic clr, input int cnt, input logic ovf,
                                   input logic udf);
      vec_t v;
      v.wr = wr; v.data = data; v.rd = rd; v.clr = clr;
      v.cnt   = 4'(cnt);
      v.full  = (cnt == 8);
      v.empty = (cnt == 0);
      v.af    = (cnt >= 7);
      v.ae    = (cnt <= 1);
      v.ovf   = ovf;
      v.udf   = udf;
      vecs.push_back(v);
   endfunction

   // One clock on the DEPTH=8 instance; the reference queue decides acceptance.
   task automatic step8(input logic wr, input logic [7:0] data, input logic rd,
                        input logic clr, input string tag);
      bit rd_acc, wr_acc;
      d_wr = wr; d_wdata = data; d_rd = rd; d_clr = clr;
      rd_acc = rd && (model_q.size() > 0);
      wr_acc = wr && ((model_q.size() < 8) || rd_acc);
      @(posedge clk);
      if (rd_acc) exp_q.push_back(model_q.pop_front());
      if (wr_acc) model_q.push_back(data);
      #1;
      d_wr = 1'b0; d_rd = 1'b0; d_clr = 1'b0;
      check({tag, "_rd_valid"}, d_rd_valid, rd_acc);
      if (rd_acc) check({tag, "_rd_data"}, d_rd_data, exp_q.pop_front());
      check({tag, "_count_model"}, d_count, model_q.size());
   endtask

   task automatic stepf(input logic wr, input logic [7:0] data, input logic rd, input string tag);
      bit rd_acc, wr_acc;
      f_wr = wr; f_wdata = data; f_rd = rd;
      rd_acc = rd && (f_q.size() > 0);
      wr_acc = wr && ((f_q.size() < 4) || rd_acc);
      @(posedge clk);
      if (rd_acc) void'(f_q.pop_front());
      if (wr_acc) f_q.push_back(data);
      #1;
      f_wr = 1'b0; f_rd = 1'b0;
      check({tag, "_count"}, f_count, f_q.size());
      check({tag, "_rd_valid"}, f_rd_valid, f_q.size() > 0);
      if (f_q.size() > 0) check({tag, "_head"}, f_rd_data, f_q[0]);
   endtask

   initial begin
      // Fill 01..08, drain, refill, overflow, clear, write-through, drain.
      for (int i = 1; i <= 8; i++) add_vec(1, 8'(i), 0, 0, i, 0, 0);
      for (int i = 1; i <= 8; i++) add_vec(0, 8'h00, 1, 0, 8 - i, 0, 0);
      for (int i = 1; i <= 8; i++) add_vec(1, 8'(8'h10 + i), 0, 0, i, 0, 0);
      add_vec(1, 8'h99, 0, 0, 8, 1, 0);
      add_vec(0, 8'h00, 0, 0, 8, 1, 0);
      add_vec(0, 8'h00, 0, 1, 8, 0, 0);
      add_vec(1, 8'hAA, 1, 0, 8, 0, 0);
      for (int i = 1; i <= 8; i++) add_vec(0, 8'h00, 1, 0, 8 - i, 0, 0);
      // Empty with simultaneous read/write; clear colliding with a new underflow.
      add_vec(1, 8'h55, 1, 0, 1, 0, 1);
      add_vec(0, 8'h00, 1, 0, 0, 0, 1);
      add_vec(0, 8'h00, 1, 1, 0, 0, 1);
      add_vec(0, 8'h00, 0, 1, 0, 0, 0);

      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("rst_count", d_count, 0);
      check("rst_empty", d_empty, 1);
      check("rst_ae", d_ae, 1);
      check("rst_full", d_full, 0);
      check("rst_af", d_af, 0);
      check("rst_rd_valid", d_rd_valid, 0);
      check("rst_rd_data", d_rd_data, 0);
      check("rst_ovf", d_ovf, 0);
      check("rst_udf", d_udf, 0);
      check("rst_f_empty", f_empty, 1);
      check("rst_f_rd_valid", f_rd_valid, 0);

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("v%0d", i);
         step8(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr, tag);
         check({tag, "_count"}, d_count, vecs[i].cnt);
         check({tag, "_full"}, d_full, vecs[i].full);
         check({tag, "_empty"}, d_empty, vecs[i].empty);
         check({tag, "_af"}, d_af, vecs[i].af);
         check({tag, "_ae"}, d_ae, vecs[i].ae);
         check({tag, "_ovf"}, d_ovf, vecs[i].ovf);
         check({tag, "_udf"}, d_udf, vecs[i].udf);
      end

      // FWFT: first word appears with no rd_en, then wrap the pointers.
      stepf(1, 8'h5A, 0, "f_first");
      check("f_first_data", f_rd_data, 8'h5A);
      check("f_first_valid", f_rd_valid, 1);
      stepf(0, 8'h00, 1, "f_pop");
      check("f_pop_empty", f_empty, 1);
      for (int i = 0; i < 10; i++) begin
         stepf(1, 8'($urandom_range(0, 255)), 0, $sformatf("f_w%0d", i));
         stepf(0, 8'h00, 1, $sformatf("f_r%0d", i));
      end
      for (int i = 0; i < 3; i++) stepf(1, 8'($urandom_range(0, 255)), 0, $sformatf("f_fill%0d", i));
      for (int i = 0; i < 10; i++) stepf(1, 8'($urandom_range(0, 255)), 1, $sformatf("f_wr%0d", i));
      for (int i = 0; i < 3; i++) stepf(0, 8'h00, 1, $sformatf("f_drain%0d", i));
      check("f_end_empty", f_empty, 1);

      // Mid-operation reset with an error flag set and stale read data held.
      step8(0, 8'h00, 1, 0, "pre_udf");
      check("pre_udf_flag", d_udf, 1);
      for (int i = 0; i < 5; i++) step8(1, 8'(8'h30 + i), 0, 0, $sformatf("pre_w%0d", i));
      check("pre_count5", d_count, 5);
      d_wr = 1'b1; d_rd = 1'b1; d_wdata = 8'hEE;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      d_wr = 1'b0; d_rd = 1'b0;
      model_q.delete();
      exp_q.delete();
      check("mid_rst_count", d_count, 0);
      check("mid_rst_empty", d_empty, 1);
      check("mid_rst_ae", d_ae, 1);
      check("mid_rst_af", d_af, 0);
      check("mid_rst_udf", d_udf, 0);
      check("mid_rst_ovf", d_ovf, 0);
      check("mid_rst_rd_valid", d_rd_valid, 0);
      check("mid_rst_rd_data", d_rd_data, 0);
      step8(1, 8'h77, 0, 0, "post_w");
      check("post_w_count", d_count, 1);
      step8(0, 8'h00, 1, 0, "post_r");
      check("post_r_data", d_rd_data, 8'h77);
      check("post_r_empty", d_empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, fully parametrised FIFO: the same-domain successor to the dual-clock FIFO, for paths where producer and consumer share one clock. Depth, width, almost-full/almost-empty thresholds and read mode (registered or first-word-fall-through) are all configurable. It adds an occupancy count, sticky overflow/underflow error flags, and write-through when full with a simultaneous read. Used as the general buffering primitive between same-clock pipeline stages.

## Interface
- DEPTH, 8: number of entries; power of two, ≥2.
- D_WIDTH, 8: data width in bits.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: 0 = registered read (data one cycle after rd_en); 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write request.
- wr_data  in  D_WIDTH  write data.
- rd_en  in  1  read/pop request.
- rd_data  out  D_WIDTH  read data.
- rd_valid  out  1  rd_data holds valid data (meaning depends on FWFT).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  AW+1  occupancy, where AW = clog2(DEPTH).
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow and underflow.

## Operation
- Storage is a DEPTH×D_WIDTH register array. Write and read pointers are AW bits and wrap naturally modulo DEPTH.
- **Read accept:** rd_acc = rd_en & ~empty.
- **Write accept:** wr_acc = wr_en & (~full | rd_acc).
  - When full, a write with a simultaneous accepted read is accepted (write-through); count stays at DEPTH.
- **Empty with simultaneous read and write:** the read is rejected and the write is accepted, in both modes.
- **count update** each cycle: +1 on wr_acc only; −1 on rd_acc only; unchanged when both or neither.
- **Flags:** full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- **FWFT=0:**
  - On rd_acc, rd_data is loaded from the head entry; rd_valid is high for exactly the following cycle.
  - Otherwise rd_data holds its last value and rd_valid is 0.
- **FWFT=1:**
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - rd_en pops the current head.
- **Error flags:**
  - overflow sets on wr_en & ~wr_acc; underflow sets on rd_en & ~rd_acc.
  - Both hold until clr_err or reset.
  - If clr_err coincides with a new error in the same cycle, set wins.
- **Reset values** (reset_n=0 at a rising edge):
  - pointers 0, count 0;
  - empty 1, almost_empty 1, full 0, almost_full 0 (almost_full 0 given AF_LEVEL ≥ 1);
  - rd_data 0, rd_valid 0, overflow 0, underflow 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries and suppresses any wr_en/rd_en in that cycle.

## Timing
- Write at edge N: count, empty and flags reflect it after edge N.
  - With FWFT=1, the first word is on rd_data in the cycle after edge N (zero added latency).
- Read latency with FWFT=0: rd_en accepted at edge N → rd_data/rd_valid valid in cycle N+1.
- Full-to-empty drain with continuous rd_en: DEPTH cycles.
  - Back-to-back writes and reads sustain 1 word per clock.
- All outputs except FWFT-mode rd_data/rd_valid are registered or pure decodes of registered count. There is no combinational path from wr_en/rd_en to any output.

## Structure
- Package fifo_pkg holds:
  - the clog2 function;
  - FWFT mode constants (FIFO_MODE_REG = 0, FIFO_MODE_FWFT = 1);
  - elaboration-time parameter checks (DEPTH power of two; AF_LEVEL/AE_LEVEL ranges).
- One sub-module, fifo_ram: single-clock 1W1R register array with synchronous write and asynchronous read, parametrised by DEPTH and D_WIDTH. The top level holds pointers, count, flags and the read-output register.

## Test plan
- **Reset/fill/drain:** DEPTH=8, FWFT=0.
  - Write 0x01..0x08 → full=1, count=8, almost_full asserted from count 7.
  - Then read 8 → rd_data 0x01..0x08 in order, each one cycle after rd_en; empty=1 after the last read.
- **Overflow:** full, wr_en with rd_en=0 → write dropped, overflow=1 and sticky. clr_err → overflow=0, count still 8.
- **Write-through at full:** full, wr_en=rd_en=1 with data 0xAA → head popped, count stays 8, 0xAA read out eighth.
- **Empty simultaneous:** empty, wr_en=rd_en=1 → underflow=1, count=1, rd_valid=0 next cycle.
- **FWFT=1, DEPTH=4:** write 0x5A → rd_data=0x5A and rd_valid=1 the next cycle with no rd_en. Pointer wrap verified over 10 write/read pairs.
- **Mid-operation reset:** reset_n=0 at count=5 → count=0, empty=1, flags cleared. The next write/read returns the new data only.
